vgaout_multi: RTL and testbench

VGAOUT_MULTI -- requirements
Module: vgaout_multi

---
 rtl/vgaout_multi.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_vgaout_multi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgaout_multi.sv
// ============================================================================
// Module      : vgaout_multi
// Description : VGA-style timing generator that overlays up to eight rows of
//               7-segment-style hex digits on a background colour.
//               Glyph units are tracked with small running sub-counters, so
//               no divider is needed to locate a pixel inside a glyph.
// Ports       : clk     - pixel clock
//               rst_n   - asynchronous active-low reset
//               values  - CHANNELS rows of DIGITS hex nibbles, MSD first
//               colors  - {r,g,b} colour per row
//               show    - per-row enable
//               hs, vs  - negative hsync / positive vsync
//               de      - data enable
//               r, g, b - 2-bit colour outputs
//               frame   - one-clock pulse at the start of each frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vgaout_multi #(
    parameter int          H_TOTAL   = 859,
    parameter int          H_SYNC    = 62,
    parameter int          H_ACT_BEG = 128,
    parameter int          H_ACT_END = 848,
    parameter int          V_TOTAL   = 526,
    parameter int          V_SYNC    = 6,
    parameter int          V_ACT_BEG = 30,
    parameter int          V_ACT_END = 510,
    parameter int          CHANNELS  = 3,
    parameter int          DIGITS    = 8,
    parameter int          SCALE     = 8,
    parameter int          X0        = 240,
    parameter int          Y0        = 112,
    parameter int          ROW_PITCH = 128,
    parameter int          LZ_BLANK  = 0,
    parameter logic [5:0]  BG        = 6'b000001
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*DIGITS*4-1:0] values,
    input  logic [CHANNELS*6-1:0]        colors,
    input  logic [CHANNELS-1:0]          show,
    output logic                         hs,
    output logic                         vs,
    output logic                         de,
    output logic [1:0]                   r,
    output logic [1:0]                   g,
    output logic [1:0]                   b,
    output logic                         frame
);

    localparam int C_HW = $clog2(H_TOTAL);
    localparam int C_VW = $clog2(V_TOTAL);
    localparam int C_KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int C_DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int C_PW = $clog2(ROW_PITCH + 1);
    localparam int C_RW = DIGITS * 4;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [C_HW-1:0] r_hcount;
    logic [C_VW-1:0] r_vcount;
    logic            w_hlast;
    logic            w_vlast;
    logic [C_HW-1:0] w_hnext;
    logic [C_VW-1:0] w_vnext;
    logic            w_sof;

    assign w_hlast = (r_hcount == C_HW'(H_TOTAL - 1));
    assign w_vlast = (r_vcount == C_VW'(V_TOTAL - 1));
    assign w_hnext = w_hlast ? '0 : r_hcount + 1'b1;
    assign w_vnext = w_vlast ? '0 : r_vcount + 1'b1;
    assign w_sof   = (r_hcount == '0) && (r_vcount == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_hcount <= w_hnext;
            if (w_hlast) begin
                r_vcount <= w_vnext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers, loaded once per frame so a frame never tears
    // ------------------------------------------------------------------
    logic [CHANNELS*DIGITS*4-1:0] r_values;
    logic [CHANNELS*6-1:0]        r_colors;
    logic [CHANNELS-1:0]          r_show;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_values <= '0;
            r_colors <= '0;
            r_show   <= '0;
        end else if (w_sof) begin
            r_values <= values;
            r_colors <= colors;
            r_show   <= show;
        end
    end

    // ------------------------------------------------------------------
    // Horizontal glyph tracker: state always describes the current hcount.
    // It is armed when the next pixel is X0 and steps through
    // SCALE pixels per unit, four units per digit.
    // ------------------------------------------------------------------
    logic            r_h_on;
    logic [C_DW-1:0] r_h_dig;
    logic [1:0]      r_h_ux;
    logic [3:0]      r_h_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_on  <= (X0 == 0);
            r_h_dig <= '0;
            r_h_ux  <= '0;
            r_h_sub <= '0;
        end else if (int'(w_hnext) == X0) begin
            r_h_on  <= 1'b1;
            r_h_dig <= '0;
            r_h_ux  <= '0;
            r_h_sub <= '0;
        end else if (r_h_on) begin
            if (r_h_sub == 4'(SCALE - 1)) begin
                r_h_sub <= '0;
                if (r_h_ux == 2'd3) begin
                    r_h_ux <= '0;
                    if (int'(r_h_dig) == DIGITS - 1) begin
                        r_h_on <= 1'b0;
                    end else begin
                        r_h_dig <= r_h_dig + 1'b1;
                    end
                end else begin
                    r_h_ux <= r_h_ux + 1'b1;
                end
            end else begin
                r_h_sub <= r_h_sub + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vertical glyph tracker, stepped at the end of each line.
    // r_v_uy reaching 5 marks the gap between a row band and the next row.
    // ------------------------------------------------------------------
    logic            r_v_on;
    logic [C_KW-1:0] r_v_row;
    logic [C_PW-1:0] r_v_pitch;
    logic [2:0]      r_v_uy;
    logic [3:0]      r_v_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_on    <= (Y0 == 0);
            r_v_row   <= '0;
            r_v_pitch <= '0;
            r_v_uy    <= '0;
            r_v_sub   <= '0;
        end else if (w_hlast) begin
            if (int'(w_vnext) == Y0) begin
                r_v_on    <= 1'b1;
                r_v_row   <= '0;
                r_v_pitch <= '0;
                r_v_uy    <= '0;
                r_v_sub   <= '0;
            end else if (r_v_on) begin
                if (int'(r_v_pitch) == ROW_PITCH - 1) begin
                    r_v_pitch <= '0;
                    r_v_uy    <= '0;
                    r_v_sub   <= '0;
                    if (int'(r_v_row) == CHANNELS - 1) begin
                        r_v_on <= 1'b0;
                    end else begin
                        r_v_row <= r_v_row + 1'b1;
                    end
                end else begin
                    r_v_pitch <= r_v_pitch + 1'b1;
                    if (r_v_uy != 3'd5) begin
                        if (r_v_sub == 4'(SCALE - 1)) begin
                            r_v_sub <= '0;
                            r_v_uy  <= r_v_uy + 1'b1;
                        end else begin
                            r_v_sub <= r_v_sub + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel generation
    // ------------------------------------------------------------------
    logic [C_RW-1:0] w_row_val;
    logic [3:0]      w_nib;
    logic [6:0]      w_seg;
    logic [2:0]      w_cells;
    logic            w_cell;
    logic            w_lead_zero;
    logic            w_blank;
    logic            w_de;
    logic            w_lit;
    logic [5:0]      w_color;
    logic [5:0]      w_rgb;

    assign w_row_val = r_values[int'(r_v_row)*C_RW +: C_RW];
    assign w_nib     = w_row_val[(DIGITS - 1 - int'(r_h_dig))*4 +: 4];
    assign w_color   = r_colors[int'(r_v_row)*6 +: 6];

    // Digit d is a leading zero when every digit from the MSD up to d is 0.
    always_comb begin
        w_lead_zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if ((d <= int'(r_h_dig)) && (w_row_val[(DIGITS-1-d)*4 +: 4] != 4'd0)) begin
                w_lead_zero = 1'b0;
            end
        end
    end

    assign w_blank = (LZ_BLANK != 0) && w_lead_zero && (int'(r_h_dig) < DIGITS - 1);

    // Segment bits are gfedcba
    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    // w_cells = {left, middle, right} column of the current unit row
    always_comb begin
        w_cells = 3'b000;
        case (r_v_uy)
            3'd0: w_cells = {w_seg[0] | w_seg[5], w_seg[0], w_seg[0] | w_seg[1]};
            3'd1: w_cells = {w_seg[5], 1'b0, w_seg[1]};
            3'd2: w_cells = {w_seg[5] | w_seg[4], w_seg[6], w_seg[1] | w_seg[2]};
            3'd3: w_cells = {w_seg[4], 1'b0, w_seg[2]};
            3'd4: w_cells = {w_seg[3] | w_seg[4], w_seg[3], w_seg[3] | w_seg[2]};
            default: w_cells = 3'b000;
        endcase
    end

    always_comb begin
        w_cell = 1'b0;
        case (r_h_ux)
            2'd0: w_cell = w_cells[2];
            2'd1: w_cell = w_cells[1];
            2'd2: w_cell = w_cells[0];
            default: w_cell = 1'b0;
        endcase
    end

    assign w_de = (int'(r_hcount) >= H_ACT_BEG) && (int'(r_hcount) < H_ACT_END) &&
                  (int'(r_vcount) >= V_ACT_BEG) && (int'(r_vcount) < V_ACT_END);

    assign w_lit = r_h_on && r_v_on && (r_v_uy != 3'd5) && w_cell && !w_blank &&
                   r_show[r_v_row];

    // Lit pixels are gated by the active window so nothing leaks into blanking
    assign w_rgb = w_de ? (w_lit ? w_color : BG) : 6'd0;

    // ------------------------------------------------------------------
    // Output registers: one clock behind the raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs    <= 1'b1;
            vs    <= 1'b0;
            de    <= 1'b0;
            frame <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else begin
            hs    <= !(int'(r_hcount) < H_SYNC);
            vs    <= (int'(r_vcount) < V_SYNC);
            de    <= w_de;
            frame <= w_sof;
            r     <= w_rgb[5:4];
            g     <= w_rgb[3:2];
            b     <= w_rgb[1:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vgaout_multi.sv
// ============================================================================
// Module      : tb_vgaout_multi
// Description : Directed self-checking bench for vgaout_multi. Two instances
//               share a reduced raster (100 x 64) so whole frames stay short:
//               instance A shows 3 rows x 8 digits at SCALE 2, instance B
//               shows 8 rows x 8 digits at SCALE 1 with leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vgaout_multi;

    localparam int HT    = 100;
    localparam int VT    = 64;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [95:0]  values_a;
    logic [17:0]  colors_a;
    logic [2:0]   show_a;
    logic         hs_a, vs_a, de_a, frame_a;
    logic [1:0]   r_a, g_a, b_a;

    logic [255:0] values_b;
    logic [47:0]  colors_b;
    logic [7:0]   show_b;
    logic         hs_b, vs_b, de_b, frame_b;
    logic [1:0]   r_b, g_b, b_b;

    vgaout_multi #(
        .H_TOTAL(HT), .H_SYNC(8), .H_ACT_BEG(16), .H_ACT_END(96),
        .V_TOTAL(VT), .V_SYNC(2), .V_ACT_BEG(4), .V_ACT_END(60),
        .CHANNELS(3), .DIGITS(8), .SCALE(2), .X0(20), .Y0(10),
        .ROW_PITCH(16), .LZ_BLANK(0), .BG(6'b000001)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .values(values_a), .colors(colors_a),
        .show(show_a), .hs(hs_a), .vs(vs_a), .de(de_a),
        .r(r_a), .g(g_a), .b(b_a), .frame(frame_a)
    );

    vgaout_multi #(
        .H_TOTAL(HT), .H_SYNC(8), .H_ACT_BEG(16), .H_ACT_END(96),
        .V_TOTAL(VT), .V_SYNC(2), .V_ACT_BEG(4), .V_ACT_END(60),
        .CHANNELS(8), .DIGITS(8), .SCALE(1), .X0(20), .Y0(4),
        .ROW_PITCH(8), .LZ_BLANK(1), .BG(6'b000001)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .values(values_b), .colors(colors_b),
        .show(show_b), .hs(hs_b), .vs(vs_b), .de(de_b),
        .r(r_b), .g(g_b), .b(b_b), .frame(frame_b)
    );

    // Edges since reset release; edge e carries raster position e-1
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Advance to the next output sample for raster position (h,v)
    task automatic goto(input int h, input int v);
        int tgt;
        tgt = (cyc / FRAME) * FRAME + v * HT + h + 1;
        if (tgt <= cyc) tgt += FRAME;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < tgt);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({hs_a, vs_a, de_a, frame_a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctl_a: got hs/vs/de/frame=%b expected 1000", {hs_a, vs_a, de_a, frame_a});
        end
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_rgb_a: got %b expected 000000", {r_a, g_a, b_a});
        end
        n_checks++;
        if ({hs_b, vs_b, de_b, frame_b, r_b, g_b, b_b} !== 10'b1000_000000) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected 1000000000", {hs_b, vs_b, de_b, frame_b, r_b, g_b, b_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timing();
        int de_cnt, hs_lo, vs_hi, fr_cnt, hs_fall;
        logic hs_prev;
        de_cnt = 0; hs_lo = 0; vs_hi = 0; fr_cnt = 0; hs_fall = 0;
        hs_prev = 1'b1;
        for (int e = 1; e <= FRAME; e++) begin
            @(posedge clk);
            #1;
            if (de_a) de_cnt++;
            if (!hs_a) hs_lo++;
            if (vs_a) vs_hi++;
            if (frame_a) fr_cnt++;
            if (hs_prev && !hs_a) hs_fall++;
            hs_prev = hs_a;
            if (e == 1) begin
                n_checks++;
                if (frame_a !== 1'b1 || frame_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_frame: got a=%b b=%b expected 1", frame_a, frame_b);
                end
            end
            if (e == 8 || e == 9) begin
                n_checks++;
                if (hs_a !== (e == 9)) begin
                    n_fail++;
                    $display("FAIL hs_edge e=%0d: got %b expected %b", e, hs_a, (e == 9));
                end
            end
            if (e == 416 || e == 417) begin
                n_checks++;
                if (de_a !== (e == 417)) begin
                    n_fail++;
                    $display("FAIL de_edge e=%0d: got %b expected %b", e, de_a, (e == 417));
                end
            end
        end
        n_checks++;
        if (de_cnt != 80 * 56) begin
            n_fail++;
            $display("FAIL de_count: got %0d expected %0d", de_cnt, 80 * 56);
        end
        n_checks++;
        if (hs_lo != 8 * VT || hs_fall != VT) begin
            n_fail++;
            $display("FAIL hs_stats: got low=%0d falls=%0d expected %0d %0d", hs_lo, hs_fall, 8 * VT, VT);
        end
        n_checks++;
        if (vs_hi != 2 * HT) begin
            n_fail++;
            $display("FAIL vs_high: got %0d expected %0d", vs_hi, 2 * HT);
        end
        n_checks++;
        if (fr_cnt != 1) begin
            n_fail++;
            $display("FAIL frame_count: got %0d expected 1", fr_cnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_a !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_period: got %b expected 1", frame_a);
        end
    endtask

    task automatic test_glyph();
        int         th[12] = '{5, 20, 25, 26, 28, 32, 90, 20, 22, 38, 20, 20};
        int         tv[12] = '{10, 10, 10, 10, 10, 10, 10, 12, 12, 14, 20, 26};
        logic [5:0] te[12] = '{6'b000000, 6'b110000, 6'b110000, 6'b000001,
                               6'b000001, 6'b110000, 6'b000001, 6'b110000,
                               6'b000001, 6'b110000, 6'b000001, 6'b000001};
        for (int i = 0; i < 12; i++) begin
            goto(th[i], tv[i]);
            n_checks++;
            if ({r_a, g_a, b_a} !== te[i]) begin
                n_fail++;
                $display("FAIL glyph_a (%0d,%0d): got %b expected %b", th[i], tv[i], {r_a, g_a, b_a}, te[i]);
            end
        end
    endtask

    task automatic test_lz_blank();
        int         th[11] = '{20, 41, 44, 45, 48, 51, 48, 49, 44, 48, 20};
        int         tv[11] = '{4, 4, 4, 4, 4, 4, 5, 5, 12, 12, 52};
        logic [5:0] te[11] = '{6'b000001, 6'b000001, 6'b110000, 6'b110000,
                               6'b110000, 6'b000001, 6'b110000, 6'b000001,
                               6'b000001, 6'b001100, 6'b000011};
        for (int i = 0; i < 11; i++) begin
            goto(th[i], tv[i]);
            n_checks++;
            if ({r_b, g_b, b_b} !== te[i]) begin
                n_fail++;
                $display("FAIL lz_b (%0d,%0d): got %b expected %b", th[i], tv[i], {r_b, g_b, b_b}, te[i]);
            end
        end
        // Row 7 starts at line 60, the first line past the active window
        goto(20, 60);
        n_checks++;
        if ({de_b, r_b, g_b, b_b} !== 7'd0) begin
            n_fail++;
            $display("FAIL row_past_active: got %b expected 0000000", {de_b, r_b, g_b, b_b});
        end
    endtask

    task automatic test_shadow();
        goto(0, 5);
        values_a[31:0] = 32'h7F00_0000;
        colors_a[5:0]  = 6'b000011;
        goto(20, 12);
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'b110000) begin
            n_fail++;
            $display("FAIL shadow_hold: got %b expected 110000", {r_a, g_a, b_a});
        end
        goto(32, 10);
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'b000011) begin
            n_fail++;
            $display("FAIL shadow_new_f: got %b expected 000011", {r_a, g_a, b_a});
        end
        goto(20, 12);
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'b000001) begin
            n_fail++;
            $display("FAIL shadow_new_7l: got %b expected 000001", {r_a, g_a, b_a});
        end
        goto(24, 12);
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'b000011) begin
            n_fail++;
            $display("FAIL shadow_new_7r: got %b expected 000011", {r_a, g_a, b_a});
        end
    endtask

    task automatic test_async_reset();
        goto(20, 10);
        n_checks++;
        if ({de_a, r_a, g_a, b_a} !== 7'b1_000011) begin
            n_fail++;
            $display("FAIL pre_reset: got %b expected 1000011", {de_a, r_a, g_a, b_a});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hs_a, vs_a, de_a, frame_a, r_a, g_a, b_a} !== 10'b1000_000000) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 1000000000", {hs_a, vs_a, de_a, frame_a, r_a, g_a, b_a});
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({hs_a, vs_a, de_a, frame_a, r_a, g_a, b_a} !== 10'b1000_000000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected 1000000000", {hs_a, vs_a, de_a, frame_a, r_a, g_a, b_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_frame: got %b expected 1", frame_a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_a !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_pulse_width: got %b expected 0", frame_a);
        end
    endtask

    initial begin
        values_a = {32'h0000_0000, 32'h8888_8888, 32'h0123_4567};
        colors_a = {6'b000011, 6'b001100, 6'b110000};
        show_a   = 3'b001;
        values_b = '0;
        values_b[31:0]    = 32'h0000_00A0;
        values_b[223:192] = 32'h8888_8888;
        values_b[255:224] = 32'h8888_8888;
        colors_b = '0;
        colors_b[5:0]   = 6'b110000;
        colors_b[11:6]  = 6'b001100;
        colors_b[41:36] = 6'b000011;
        colors_b[47:42] = 6'b111111;
        show_b   = 8'b1100_0011;

        test_reset();
        test_timing();
        test_glyph();
        test_lz_blank();
        test_shadow();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
